// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : Shared constants for the DES S-box scheduler: S1..S8 lookup
//             tables, P-permutation index table, scheduler state encoding
//             and the legal LANES set.
//  Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    // Each S-box is 64 nibbles indexed by row*16+col; entry 0 is the
    // leftmost nibble of the literal so rows read exactly like the tables.
    localparam logic [0:63][3:0] SBOX [8] = '{
        {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Output bit i+1 of P takes input bit P_TABLE[i] (DES bit numbering).
    localparam logic [0:31][5:0] P_TABLE = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    // Lane counts that divide the eight groups evenly.
    localparam int LANES_LEGAL [4] = '{1, 2, 4, 8};

    function automatic bit lanes_legal(input int lanes);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (LANES_LEGAL[i] == lanes) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_lane.sv
`default_nettype none
// ============================================================================
//  Module   : des_sbox_lane
//  Purpose  : Combinational lookup into one of the eight DES S-boxes.
//             Row = {b1,b6}, column = {b2..b5} of the 6-bit group.
//  Revision : 1.0 - initial release
// ============================================================================
module des_sbox_lane (
    input  logic [2:0] sel,
    input  logic [1:6] in,
    output logic [1:4] out
);
    import des_pkg::*;

    logic [5:0] lin;

    // Linear table index row*16+col built directly from the group bits.
    assign lin = {in[1], in[6], in[2:5]};
    assign out = SBOX[sel][lin];

endmodule
`default_nettype wire

// File: rtl/des_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : des_sbox_sched
//  Purpose  : Time-multiplexes LANES shared S-box lanes over the eight 6-bit
//             groups of a DES f-function. One 48-bit word in, one 32-bit
//             substitution result out, both over valid/ready.
//  Options  : define SBOX_SCHED_PERM_EN to apply the P-permutation on the
//             output register (combinational, no extra latency).
//  Revision : 1.0 - initial release
// ============================================================================
module des_sbox_sched #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:48] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [1:32] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    import des_pkg::*;

    localparam int STEPS = 8 / LANES;
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(STEPS - 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:48]      din_q, din_d;
    logic [1:32]      res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             load;

    logic [2:0]       lane_sel [LANES];
    logic [1:6]       lane_in  [LANES];
    logic [1:4]       lane_out [LANES];

    if (!lanes_legal(LANES)) begin : g_lanes_check
        $error("des_sbox_sched: LANES must be 1, 2, 4 or 8");
    end

    // Lane k handles group idx*LANES+k this cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_sel[k] = 3'(int'(idx_q) * LANES + k);
        assign lane_in[k]  = din_q[6*int'(lane_sel[k]) + 1 +: 6];

        des_sbox_lane u_lane (
            .sel (lane_sel[k]),
            .in  (lane_in[k]),
            .out (lane_out[k])
        );
    end

    // Ready in IDLE, passes consumer ready through while holding a result.
    assign in_ready = out_valid_q ? out_ready : ~busy_q;
    assign load     = in_valid & in_ready;

    // Next-state, group walk and result assembly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        din_d   = din_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    din_d   = in_data;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < LANES; k++) begin
                    res_d[4*int'(lane_sel[k]) + 1 +: 4] = lane_out[k];
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Accepting the next word on the same edge avoids an IDLE bubble.
                if (load) begin
                    din_d   = in_data;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            din_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            din_q       <= din_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef SBOX_SCHED_PERM_EN
    // P-permutation wired onto the held result.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 32; i++) begin
            out_data[i+1] = res_q[P_TABLE[i]];
        end
    end
`else
    assign out_data = res_q;
`endif

endmodule
`default_nettype wire

// File: doc/des_sbox_sched.md
Name: des_sbox_sched

Overview:
- Sequencer that time-multiplexes a reduced number of shared S-box lookup lanes across the eight 6-bit groups of a DES f-function.
- Accepts one 48-bit (E-expanded XOR subkey) word per transaction over a valid/ready handshake and walks the groups S1..S8 over 8/LANES cycles.
- Assembles the 32-bit substitution result and presents it downstream over valid/ready.
- Sits between the key-mix XOR and the P-permutation stage of the round datapath; used in area-reduced cores.

Parameters:
- LANES, 1, lookups per cycle; legal values 1, 2, 4, 8. Any other value is a elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  [1:48]  DES bit numbering; bits [1:6] feed S1, and so on through [43:48] for S8
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- out_data  output  [1:32]  bits [1:4] = S1 result, and so on through [29:32] = S8 result
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high in RUN

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, state=IDLE, idx=0, input register=0.
- Async reset takes effect immediately, including mid-RUN or while DONE is holding data. Any partial result is discarded and no out_valid pulse follows.
- Lookup rule: 6-bit group g = b1..b6. Row = {b1,b6}, column = {b2,b3,b4,b5}. Tables are the FIPS 46-3 S1..S8.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch in_data, set idx=0, go to RUN.
- State RUN:
  - in_ready=0, busy=1.
  - Each cycle evaluates groups idx*LANES .. idx*LANES+LANES-1 and writes the 4-bit results into their out_data slots.
  - idx increments by 1; when idx = 8/LANES-1 the state goes to DONE.
  - RUN lasts exactly 8/LANES cycles.
- State DONE:
  - out_valid=1 and out_data is held stable until accepted.
  - When out_valid & out_ready:
    - if in_valid is also high, latch the new word and go straight to RUN (back-to-back, no IDLE bubble);
    - otherwise go to IDLE.
  - in_ready = out_ready while in DONE.
- Latency: out_valid rises 8/LANES cycles after the accepting clock edge. Sustained throughput is one word per 8/LANES+1 cycles.
- in_valid in RUN is ignored: in_ready=0, so no accept occurs. in_data may change in RUN without effect because the input is registered.
- out_data slots not yet written in RUN keep their previous values. They are not observable because out_valid=0.
- idx width is clog2(8/LANES), minimum 1 bit. It wraps to 0 on entry to RUN.

Optional Feature:
- Macro SBOX_SCHED_PERM_EN.
- Defined: out_data carries the FIPS 46-3 P-permutation of the assembled 32-bit result. The permutation is applied combinationally on the DONE output register; latency is unchanged.
- Undefined: out_data is the raw S1..S8 concatenation, and no P logic is instantiated.

Decomposition:
- Shared package des_pkg holds:
  - S1..S8 tables as a constant array [8][64] of 4-bit values, indexed by linear (row*16+col);
  - the P-permutation index table;
  - the state enum (IDLE/RUN/DONE);
  - the legal-LANES check constant.
- One sub-module is natural: des_sbox_lane, a combinational lookup with ports sel[2:0] (which S-box), in[1:6] and out[1:4].
  - The scheduler instantiates LANES copies.
  - Copy k uses sel = idx*LANES+k.

Test Plan:
- LANES=1, in_data=48'h0, out_ready=1 -> out_valid high exactly 8 cycles after accept, out_data=32'hEFA72C4D, busy high for 8 cycles.
- LANES=8, in_data=48'hFFFFFFFFFFFF -> out_valid 1 cycle after accept, out_data=32'hD9CE3DCB; repeat with LANES=2 and LANES=4 -> same data, latency 4 and 2.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable at 32'hEFA72C4D; in_valid pulses during RUN and DONE are not accepted (in_ready=0); on out_ready=1 with in_valid=1 the next word is accepted in the same cycle.
- Back-to-back: 4 words with in_valid and out_ready held high, LANES=1 -> one out_valid every 9 cycles, results match the golden model in order.
- rst asserted asynchronously mid-RUN (idx=3) -> out_valid=0, in_ready=1, out_data=0 immediately; no output is produced for the aborted word.
- SBOX_SCHED_PERM_EN defined, 1000 random inputs -> out_data equals P(S(in)) from the golden model; undefined -> equals S(in).
